matrix_scan_ctrl: RTL and testbench
===================================

MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 499, sets the bit-tick period to CLK_DIV+1 clk cycles (10 us at 50 MHz).
REQ-002 Parameter FETCH_WAIT_MAX, default 255, sets the maximum clk cycles row_req may wait for row_valid.
REQ-003 Port clk, input, 1 bit: single clock, 50 MHz system clock; all logic is in this domain.
REQ-004 Port clr, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port en, input, 1 bit: scan enable.
REQ-006 Port row_req, output, 1 bit: row fetch request to the frame store.
REQ-007 Port row_addr, output, 4 bits: row index being fetched or displayed.
REQ-008 Port row_data, input, 16 bits: pixel word for row_addr, where 1 means lit.
REQ-009 Port row_valid, input, 1 bit: row_data is valid.
REQ-010 Port ser_data, output, 1 bit: serial pixel data to the row shift chain.
REQ-011 Port ser_col, output, 1 bit: serial one-hot column-select data to the select shift chain.
REQ-012 Port srclk, output, 1 bit: shift clock to both chains.
REQ-013 Port rclk, output, 1 bit: storage latch clock to both chains.
REQ-014 Port oe_n, output, 1 bit: output enable to both chains, active-low.
REQ-015 Port frame_start, output, 1 bit: one-clk pulse when a row-0 fetch begins.
REQ-016 Port busy, output, 1 bit: high in any state except IDLE.
REQ-017 Port fetch_err, output, 1 bit: sticky flag set on a fetch timeout.

Function
REQ-018 The block SHALL implement the states IDLE, FETCH, SHIFT, LATCH and NEXT.
REQ-019 IDLE SHALL move to FETCH on the first clk with en=1.
REQ-020 FETCH SHALL hold row_req=1 and a stable row_addr until row_req&&row_valid is seen at a clk edge.
REQ-021 On that FETCH edge the block SHALL capture row_data, clear row_req on the next cycle, and enter SHIFT.
REQ-022 If FETCH waits FETCH_WAIT_MAX cycles, the block SHALL set fetch_err, load an all-zero row word, and enter SHIFT.
REQ-023 All srclk, rclk, ser_data and ser_col changes SHALL occur only on a bit-tick; between ticks the FSM SHALL hold.
REQ-024 SHIFT SHALL spend 32 ticks; for bit k = 15 down to 0, tick 2k' drives ser_data=word[k] and ser_col=(k==row_addr) with srclk=0, and the next tick sets srclk=1.
REQ-025 After the 32nd SHIFT tick the block SHALL enter LATCH.
REQ-026 LATCH SHALL drive srclk=0 and rclk=1 for one tick, then rclk=0 for one tick, then go to NEXT.
REQ-027 NEXT SHALL increment row_addr modulo 16, with 15 wrapping to 0.
REQ-028 NEXT SHALL go to FETCH if en=1 and to IDLE otherwise.
REQ-029 frame_start SHALL pulse on the FETCH entry cycle whenever row_addr=0.
REQ-030 Deasserting en mid-row SHALL NOT abort the row; the row completes through LATCH and NEXT first.
REQ-031 The tick counter SHALL free-run while busy, be held at 0 in IDLE, and fire its first tick CLK_DIV+1 cycles after leaving FETCH.
REQ-032 If row_valid arrives in the same cycle as a timeout, the valid data SHALL win and fetch_err SHALL NOT be set.
REQ-033 fetch_err SHALL be cleared only by reset.

Reset
REQ-034 Asserting clr low SHALL immediately force state=IDLE, row_addr=0, row_req=0, ser_data=0, ser_col=0, srclk=0, rclk=0, oe_n=1, frame_start=0, busy=0 and fetch_err=0, and clear the tick counter.
REQ-035 Reset asserted mid-SHIFT SHALL abandon the row; after release, the scan restarts at row 0 with frame_start.

Configuration
REQ-036 When MATRIX_SCAN_BLANK_EN is defined, oe_n SHALL be 1 from entry to LATCH until one tick after rclk falls, and 0 otherwise while busy.
REQ-037 When MATRIX_SCAN_BLANK_EN is undefined, oe_n SHALL be 0 whenever busy and 1 in IDLE.

Structure
REQ-038 Package matrix_pkg SHALL hold the state enumeration, MATRIX_ROWS=16, MATRIX_COLS=16 and TICKS_PER_ROW=32.
REQ-039 Sub-module matrix_tick_gen SHALL hold the CLK_DIV prescaler, with a clear input and a one-clk tick output.

Verification
REQ-040 Bench SHALL cover: clr low, then release with en=1 and row_valid tied 1 with CLK_DIV=3 -> frame_start at the row-0 FETCH; exactly 16 srclk rising edges per row; one rclk pulse per row.
REQ-041 Bench SHALL cover: row_addr=5 and row_data=16'hA5C3 -> ser_data sampled at srclk rises equals 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1, and ser_col is 1 only at the 11th rise.
REQ-042 Bench SHALL cover: row_valid held low for 300 cycles with FETCH_WAIT_MAX=255 -> fetch_err=1 at cycle 255, the row shifts all zeros, and the scan continues.
REQ-043 Bench SHALL cover: en dropped at SHIFT tick 10 of row 7 -> row 7 latches, row_addr becomes 8, busy falls, and there are no further srclk edges.
REQ-044 Bench SHALL cover: clr pulsed low at SHIFT tick 20 of row 12 -> all outputs take reset values in the same cycle, and after release the first fetch uses row_addr=0.
REQ-045 Bench SHALL cover: running row 15 to NEXT -> row_addr=0 and frame_start pulses once; with MATRIX_SCAN_BLANK_EN defined, oe_n=1 is seen across every rclk pulse.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and sizing for the LED matrix scan controller.
package matrix_pkg;

  localparam int MATRIX_ROWS   = 16;
  localparam int MATRIX_COLS   = 16;
  localparam int TICKS_PER_ROW = 32;
  localparam int ROW_W         = $clog2(MATRIX_ROWS);
  localparam int TIDX_W        = $clog2(TICKS_PER_ROW);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_LATCH,
    ST_NEXT
  } scan_state_t;

  function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] r);
    return r + ROW_W'(1);
  endfunction

endpackage

// File: rtl/matrix_tick_gen.sv
// Bit-tick prescaler: one-clk tick every CLK_DIV+1 cycles, held at zero while hold is high.
module matrix_tick_gen #(
  parameter int CLK_DIV = 499
) (
  input  logic clk,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int CW = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam logic [CW-1:0] TC = CW'(CLK_DIV);

  logic [CW-1:0] cnt;

  assign tick = !hold && (cnt == TC);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (hold || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-scan controller: fetches a row word, shifts it out with a one-hot column select, latches.
// Optional build macro MATRIX_SCAN_BLANK_EN blanks oe_n around the latch pulse.
//
// state    | meaning
// ST_IDLE  | scan stopped, outputs parked
// ST_FETCH | row_req high, waiting for row_valid or timeout
// ST_SHIFT | 32 ticks: data/select set up, then srclk rise, per bit
// ST_LATCH | rclk high for one tick, then low for one tick
// ST_NEXT  | advance row_addr, continue or stop on en
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int CLK_DIV        = 499,
  parameter int FETCH_WAIT_MAX = 255
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   en,
  output logic                   row_req,
  output logic [ROW_W-1:0]       row_addr,
  input  logic [MATRIX_COLS-1:0] row_data,
  input  logic                   row_valid,
  output logic                   ser_data,
  output logic                   ser_col,
  output logic                   srclk,
  output logic                   rclk,
  output logic                   oe_n,
  output logic                   frame_start,
  output logic                   busy,
  output logic                   fetch_err
);

  localparam int WW = $clog2(FETCH_WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(FETCH_WAIT_MAX - 1);

  scan_state_t            state;
  logic [MATRIX_COLS-1:0] word;
  logic [TIDX_W-1:0]      tick_idx;
  logic [WW-1:0]          wait_cnt;
  logic [ROW_W-1:0]       bit_k;
  logic                   tick;
  logic                   tick_hold;

  // Prescaler restarts on leaving FETCH so the first shift tick lands a full period later.
  assign tick_hold = (state == ST_IDLE) || (state == ST_FETCH);
  assign bit_k     = ~tick_idx[TIDX_W-1:1];

  matrix_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .clr  (clr),
    .hold (tick_hold),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= ST_IDLE;
      row_addr    <= '0;
      row_req     <= 1'b0;
      ser_data    <= 1'b0;
      ser_col     <= 1'b0;
      srclk       <= 1'b0;
      rclk        <= 1'b0;
      oe_n        <= 1'b1;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      fetch_err   <= 1'b0;
      word        <= '0;
      tick_idx    <= '0;
      wait_cnt    <= '0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            state       <= ST_FETCH;
            row_req     <= 1'b1;
            busy        <= 1'b1;
            oe_n        <= 1'b0;
            wait_cnt    <= WAIT_LOAD;
            frame_start <= (row_addr == '0);
          end
        end
        ST_FETCH: begin
          // valid data takes priority over a timeout in the same cycle
          if (row_valid) begin
            word     <= row_data;
            row_req  <= 1'b0;
            tick_idx <= '0;
            state    <= ST_SHIFT;
          end else if (wait_cnt == '0) begin
            fetch_err <= 1'b1;
            word      <= '0;
            row_req   <= 1'b0;
            tick_idx  <= '0;
            state     <= ST_SHIFT;
          end else begin
            wait_cnt <= wait_cnt - WW'(1);
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (!tick_idx[0]) begin
              ser_data <= word[bit_k];
              ser_col  <= (bit_k == row_addr);
              srclk    <= 1'b0;
`ifdef MATRIX_SCAN_BLANK_EN
              if (tick_idx == '0) oe_n <= 1'b0;
`endif
            end else begin
              srclk <= 1'b1;
            end
            if (tick_idx == TIDX_W'(TICKS_PER_ROW - 1)) begin
              tick_idx <= '0;
              state    <= ST_LATCH;
`ifdef MATRIX_SCAN_BLANK_EN
              oe_n     <= 1'b1;
`endif
            end else begin
              tick_idx <= tick_idx + TIDX_W'(1);
            end
          end
        end
        ST_LATCH: begin
          if (tick) begin
            if (!tick_idx[0]) begin
              srclk    <= 1'b0;
              rclk     <= 1'b1;
              tick_idx <= TIDX_W'(1);
            end else begin
              rclk  <= 1'b0;
              state <= ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          row_addr <= next_row(row_addr);
          if (en) begin
            state       <= ST_FETCH;
            row_req     <= 1'b1;
            wait_cnt    <= WAIT_LOAD;
            frame_start <= (row_addr == ROW_W'(MATRIX_ROWS - 1));
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            oe_n  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl with CLK_DIV=3 and FETCH_WAIT_MAX=255.
module tb_matrix_scan_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        en;
  logic        row_req;
  logic [3:0]  row_addr;
  logic [15:0] row_data;
  logic        row_valid;
  logic        ser_data, ser_col, srclk, rclk, oe_n, frame_start, busy, fetch_err;
  logic [12:0] outs_vec;

  int n_chk = 0;
  int n_bad = 0;

  always #10 clk = ~clk;

  matrix_scan_ctrl #(.CLK_DIV(3), .FETCH_WAIT_MAX(255)) dut (
    .clk         (clk),
    .clr         (clr),
    .en          (en),
    .row_req     (row_req),
    .row_addr    (row_addr),
    .row_data    (row_data),
    .row_valid   (row_valid),
    .ser_data    (ser_data),
    .ser_col     (ser_col),
    .srclk       (srclk),
    .rclk        (rclk),
    .oe_n        (oe_n),
    .frame_start (frame_start),
    .busy        (busy),
    .fetch_err   (fetch_err)
  );

  function automatic logic [15:0] rom_word(input int r);
    case (r)
      0: return 16'h8001;   1: return 16'h1234;   2: return 16'hFFFF;   3: return 16'h0F0F;
      4: return 16'h00FF;   5: return 16'hA5C3;   6: return 16'h5A5A;   7: return 16'hC3C3;
      8: return 16'h7E7E;   9: return 16'h0001;  10: return 16'h8000;  11: return 16'hAAAA;
      12: return 16'h5555; 13: return 16'h3333;  14: return 16'hCCCC;  15: return 16'hF00F;
      default: return 16'h0000;
    endcase
  endfunction

  assign row_data = rom_word(int'(row_addr));
  assign outs_vec = {row_req, row_addr, ser_data, ser_col, srclk, rclk,
                     oe_n, frame_start, busy, fetch_err};

  // per-row observation of the shift chains, snapshotted whenever row_addr moves
  int          cyc = 0, n_sr = 0, n_rc = 0, gap = 0, last_rise = 0, fs_cnt = 0, rows_done = 0;
  int          d_sr = 0, d_rc = 0, d_gap = 0;
  logic [15:0] sd_w = '0, sc_w = '0, d_sd = '0, d_sc = '0;
  logic        oe_all = 1'b1, oe_any = 1'b0, d_oe_all = 1'b1, d_oe_any = 1'b0;
  logic        srclk_q = 1'b0, rclk_q = 1'b0;
  logic [3:0]  addr_q = '0;

  always @(negedge clk) begin
    cyc++;
    if (!clr) begin
      n_sr = 0; n_rc = 0; gap = 0; sd_w = '0; sc_w = '0; oe_all = 1'b1; oe_any = 1'b0;
    end else begin
      if (frame_start) fs_cnt++;
      if (srclk && !srclk_q) begin
        n_sr++;
        gap = cyc - last_rise;
        last_rise = cyc;
        sd_w = {sd_w[14:0], ser_data};
        sc_w = {sc_w[14:0], ser_col};
      end
      if (rclk && !rclk_q) n_rc++;
      if (rclk) begin
        oe_all = oe_all & oe_n;
        oe_any = oe_any | oe_n;
      end
      if (row_addr != addr_q) begin
        d_sr = n_sr; d_rc = n_rc; d_gap = gap; d_sd = sd_w; d_sc = sc_w;
        d_oe_all = oe_all; d_oe_any = oe_any;
        rows_done++;
        n_sr = 0; n_rc = 0; sd_w = '0; sc_w = '0; oe_all = 1'b1; oe_any = 1'b0;
      end
    end
    srclk_q = srclk;
    rclk_q  = rclk;
    addr_q  = row_addr;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_row(output logic ok);
    int start;
    start = rows_done;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (rows_done != start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_sr(input logic [3:0] a, input int n, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (row_addr == a && n_sr == n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_fs(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (frame_start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic row_checks(input int r, input logic [15:0] exp_word);
    logic ok;
    wait_row(ok);
    check_val($sformatf("row%0d_wait", r), ok, 1);
    check_val($sformatf("row%0d_srclk_rises", r), d_sr, 16);
    check_val($sformatf("row%0d_rclk_pulses", r), d_rc, 1);
    check_val($sformatf("row%0d_ser_data", r), d_sd, exp_word);
    check_val($sformatf("row%0d_ser_col", r), d_sc, 16'h0001 << r);
`ifdef MATRIX_SCAN_BLANK_EN
    check_val($sformatf("row%0d_oe_blank", r), d_oe_all, 1);
`else
    check_val($sformatf("row%0d_oe_on", r), d_oe_any, 0);
`endif
  endtask

  initial begin
    logic ok;
    int   fs0;
    clr = 1'b1; en = 1'b0; row_valid = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0; #1;
    check_val("rst_outs", outs_vec, 13'h008);
    repeat (3) @(negedge clk); #1;
    check_val("rst_hold", outs_vec, 13'h008);

    clr = 1'b1; en = 1'b1;
    wait_fs(ok);
    check_val("fs_row0_wait", ok, 1);
    check_val("fs_row0_addr", row_addr, 0);
    check_val("fs_row0_req", row_req, 1);
    row_checks(0, rom_word(0));
    check_val("srclk_period", d_gap, 8);
    for (int r = 1; r < 5; r++) row_checks(r, rom_word(r));

    // starve the row-6 fetch
    wait_sr(4'd5, 8, ok);
    check_val("sr5_wait", ok, 1);
    row_valid = 1'b0;
    row_checks(5, 16'hA5C3);
    check_val("to_addr", row_addr, 6);
    check_val("to_req", row_req, 1);
    repeat (254) @(negedge clk);
    #1;
    check_val("err_at_254", fetch_err, 0);
    @(negedge clk); #1;
    check_val("err_at_255", fetch_err, 1);
    check_val("to_req_drop", row_req, 0);
    repeat (44) @(negedge clk);
    row_valid = 1'b1;
    row_checks(6, 16'h0000);

    // drop en at SHIFT tick 10 of row 7
    wait_sr(4'd7, 5, ok);
    check_val("sr7_wait", ok, 1);
    en = 1'b0;
    row_checks(7, rom_word(7));
    check_val("stop_addr", row_addr, 8);
    repeat (100) @(negedge clk);
    #1;
    check_val("stop_busy", busy, 0);
    check_val("stop_srclk", n_sr, 0);
    check_val("stop_rclk", n_rc, 0);
    check_val("stop_addr_hold", row_addr, 8);
    check_val("stop_oe", oe_n, 1);
    check_val("err_sticky", fetch_err, 1);

    fs0 = fs_cnt;
    en = 1'b1;
    for (int r = 8; r < 12; r++) row_checks(r, rom_word(r));
    check_val("no_fs_mid", fs_cnt, fs0);

    // reset at SHIFT tick 20 of row 12
    wait_sr(4'd12, 10, ok);
    check_val("sr12_wait", ok, 1);
    clr = 1'b0; #1;
    check_val("midrow_rst_outs", outs_vec, 13'h008);
    repeat (3) @(negedge clk);
    clr = 1'b1;
    wait_fs(ok);
    check_val("fs_restart_wait", ok, 1);
    check_val("restart_addr", row_addr, 0);
    fs0 = fs_cnt;
    for (int r = 0; r < 16; r++) row_checks(r, rom_word(r));
    check_val("wrap_addr", row_addr, 0);
    check_val("wrap_fs", frame_start, 1);
    @(negedge clk); #1;
    check_val("wrap_fs_once", fs_cnt, fs0 + 1);
    check_val("err_cleared", fetch_err, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
